// File: rtl/sp_ram_arb_pkg.sv
// rtl/sp_ram_arb_pkg.sv - shared types for the single-port RAM arbiter
// Purpose: names the arbitration sides so the round-robin pointer reads clearly.
// Ports: none (package).
package sp_ram_arb_pkg;

  // Which requester won the most recent accepted transfer.
  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_e;

endpackage

// File: rtl/sp_ram_arb_rsp_fifo2.sv
// rtl/sp_ram_arb_rsp_fifo2.sv - two-entry read response buffer
// Purpose: holds up to two read responses; the head entry is a flop so the
//          output data is registered with no read mux.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push, push_data       write one entry at the tail
//   pop                   remove the head entry (ignored when empty)
//   count                 number of valid entries (0..2)
//   head_data             oldest entry, zero after reset
module rsp_fifo2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] e0_q, e0_d;
  logic [DATA_WIDTH-1:0] e1_q, e1_d;
  logic [1:0]            count_q, count_d;
  logic                  pop_ok;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    pop_ok  = pop && (count_q != 2'd0);
    case ({push, pop_ok})
      2'b10: begin
        // A push into a full buffer is dropped; the arbiter's credit prevents it.
        if (count_q == 2'd0) begin
          e0_d    = push_data;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          e1_d    = push_data;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        // Entries shift toward the head so e0 is always the oldest.
        e0_d    = e1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          e0_d = push_data;
        end else begin
          e0_d = e1_q;
          e1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign head_data = e0_q;

endmodule

// File: rtl/sp_ram_arb.sv
// rtl/sp_ram_arb.sv - read/write arbiter in front of an external single-port RAM
// Purpose: accepts at most one write or read per cycle, round-robin on contention,
//          and returns read data in order through a two-entry response buffer.
// Ports:
//   clka, rsta                         clock, asynchronous active-high reset
//   wr_valid/wr_ready, wr_addr/wr_data write request
//   rd_valid/rd_ready, rd_addr         read request
//   rsp_valid/rsp_ready, rsp_data      read response (registered data)
//   ram_ena/ram_wea/ram_addra/ram_dina RAM port controls (combinational)
//   ram_douta                          RAM read data, one cycle after a read issue
import sp_ram_arb_pkg::*;

module sp_ram_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  input  logic [DATA_WIDTH-1:0] ram_douta
);

  grant_e     last_grant_q, last_grant_d;
  logic       inflight_q, inflight_d;
  logic [1:0] fifo_count;
  logic       rsp_pop;
  logic [2:0] rd_load;
  logic       rd_credit;
  logic       wr_elig, rd_elig;
  logic       gnt_wr, gnt_rd;

  assign rsp_pop = rsp_valid & rsp_ready;

  // Reads buffered plus the one whose data lands next cycle, less the one leaving
  // now, must stay below the buffer depth so the push never finds it full.
  assign rd_load   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, rsp_pop};
  assign rd_credit = (rd_load < 3'd2);

  always_comb begin
    wr_elig      = 1'b0;
    rd_elig      = 1'b0;
    gnt_wr       = 1'b0;
    gnt_rd       = 1'b0;
    last_grant_d = last_grant_q;
    if (!rsta) begin
      wr_elig = wr_valid;
      rd_elig = rd_valid & rd_credit;
      if (wr_elig && rd_elig) begin
        if (last_grant_q == GNT_RD) gnt_wr = 1'b1;
        else                        gnt_rd = 1'b1;
      end else begin
        gnt_wr = wr_elig;
        gnt_rd = rd_elig;
      end
    end
    if (gnt_wr)      last_grant_d = GNT_WR;
    else if (gnt_rd) last_grant_d = GNT_RD;
    inflight_d = gnt_rd;
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      last_grant_q <= GNT_RD;
      inflight_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      inflight_q   <= inflight_d;
    end
  end

  assign wr_ready  = gnt_wr;
  assign rd_ready  = gnt_rd;
  assign ram_ena   = gnt_wr | gnt_rd;
  assign ram_wea   = gnt_wr;
  assign ram_addra = gnt_wr ? wr_addr : rd_addr;
  assign ram_dina  = wr_data;

  rsp_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rsp_fifo2 (
    .clk      (clka),
    .rst      (rsta),
    .push     (inflight_q),
    .push_data(ram_douta),
    .pop      (rsp_pop),
    .count    (fifo_count),
    .head_data(rsp_data)
  );

  assign rsp_valid = (fifo_count != 2'd0);

endmodule

// File: tb/tb_sp_ram_arb.sv
// tb/tb_sp_ram_arb.sv - scoreboard bench for sp_ram_arb
module tb_sp_ram_arb;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clka = 1'b0;
  logic          rsta;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          ram_ena, ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina;
  logic [DW-1:0] ram_douta = '0;

  always #5 clka = ~clka;

  sp_ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clka(clka), .rsta(rsta),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
    .ram_dina(ram_dina), .ram_douta(ram_douta)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return (i * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  // External single-port RAM emulation, driven only by the DUT's RAM port.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clka) begin
    if (ram_ena) begin
      if (ram_wea) ram_mem[ram_addra] <= ram_dina;
      else         ram_douta <= ram_mem[ram_addra];
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clka) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory contents seen through accepted handshakes, and the
  // queue of accepted reads (expected data + acceptance cycle) not yet returned.
  typedef struct {
    logic [DW-1:0] data;
    int            acc_cyc;
  } exp_t;

  logic [DW-1:0] ref_mem [DEPTH];
  exp_t          sb[$];
  bit            model_last_wr;
  bit            exp_valid, pop_now, rd_ok, exp_w, exp_r;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    model_last_wr = 1'b0;
    forever begin
      @(negedge clka);
      if (rsta) begin
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_ram_ena", ram_ena, 0);
        check("rst_ram_wea", ram_wea, 0);
        sb.delete();
        model_last_wr = 1'b0;
      end else begin
        // A read's data is available two cycles after it was accepted.
        exp_valid = (sb.size() > 0) && (sb[0].acc_cyc <= cyc - 2);
        pop_now   = exp_valid && rsp_ready;
        rd_ok     = rd_valid && ((sb.size() - (pop_now ? 1 : 0)) < 2);
        if (wr_valid && rd_ok) begin
          exp_w = !model_last_wr;
          exp_r = model_last_wr;
        end else begin
          exp_w = wr_valid;
          exp_r = rd_ok;
        end
        check("rsp_valid", rsp_valid, exp_valid);
        check("wr_ready", wr_ready, exp_w);
        check("rd_ready", rd_ready, exp_r);
        check("ram_ena", ram_ena, exp_w | exp_r);
        if (exp_w) begin
          check("wr_ram_wea", ram_wea, 1);
          check("wr_ram_addra", ram_addra, wr_addr);
          check("wr_ram_dina", ram_dina, wr_data);
        end else begin
          check("ram_wea_low", ram_wea, 0);
        end
        if (exp_r) check("rd_ram_addra", ram_addra, rd_addr);
        if (pop_now) begin
          check("rsp_data", rsp_data, sb[0].data);
          void'(sb.pop_front());
        end
        if (exp_w) begin
          ref_mem[wr_addr] = wr_data;
          model_last_wr    = 1'b1;
        end
        if (exp_r) begin
          sb.push_back('{data: ref_mem[rd_addr], acc_cyc: cyc});
          model_last_wr = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic idle(input int n);
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clka);
      if (wr_ready) begin
        acc = 1'b1;
        break;
      end
      step();
    end
    step();
    wr_valid = 1'b0;
    check("write_accept_timeout", acc, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    bit acc = 1'b0;
    rd_valid = 1'b1;
    rd_addr  = a;
    for (int k = 0; k < 50; k++) begin
      @(negedge clka);
      if (rd_ready) begin
        acc = 1'b1;
        break;
      end
      step();
    end
    step();
    rd_valid = 1'b0;
    check("read_accept_timeout", acc, 1);
  endtask

  initial begin
    logic [11:0] rr_pat;
    logic [9:0]  burst_pat;
    int          n_acc, n_pop, idx;

    rsta = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
    repeat (3) step();
    rsta = 1'b0;
    step();

    // Write then read the same address; data two cycles after read accept.
    do_write(10'd3, 32'hA5A5_0001);
    do_read(10'd3);
    @(negedge clka);
    check("lat_n1_rsp_valid", rsp_valid, 0);
    step();
    @(negedge clka);
    check("lat_n2_rsp_valid", rsp_valid, 1);
    check("lat_n2_rsp_data", rsp_data, 32'hA5A5_0001);
    step();
    idle(2);

    // Contention: last grant was a read, so the write goes first, then alternate.
    rr_pat = '0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(100 + i); wr_data = $urandom;
      rd_valid = 1'b1; rd_addr = AW'(100 + i);
      @(negedge clka);
      rr_pat = {rr_pat[9:0], wr_ready, rd_ready};
      step();
    end
    check("rr_pattern", rr_pat, 12'b10_01_10_01_10_01);
    idle(4);

    // Backpressure: only two reads may be outstanding.
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      rd_valid = 1'b1; rd_addr = AW'(20 + i);
      @(negedge clka);
      if (rd_ready) n_acc++;
      if (i == 4) check("bp_rd_ready_last", rd_ready, 0);
      step();
    end
    check("bp_accepts", n_acc, 2);
    rsp_ready = 1'b1;
    n_acc = 0;
    n_pop = 0;
    for (int i = 0; i < 6; i++) begin
      rd_valid = 1'b1; rd_addr = AW'(30 + i);
      @(negedge clka);
      if (rd_ready) n_acc++;
      if (rsp_valid) n_pop++;
      step();
    end
    check("resume_accepts", n_acc, 6);
    check("resume_responses", n_pop, 6);
    idle(4);

    // Back-to-back reads of addresses 0..7.
    idx = 0;
    burst_pat = '0;
    for (int k = 0; k < 10; k++) begin
      rd_valid = (idx < 8);
      rd_addr  = AW'(idx);
      @(negedge clka);
      burst_pat = {burst_pat[8:0], rsp_valid};
      if (rd_valid && rd_ready) idx++;
      step();
    end
    check("burst_accepts", idx, 8);
    check("burst_rsp_pattern", burst_pat, 10'b00_1111_1111);
    idle(3);

    // Reset one cycle after a read accept discards the pending response.
    do_read(10'd5);
    rsta = 1'b1;
    wr_valid = 1'b1; rd_valid = 1'b1;
    @(negedge clka);
    check("rst_mid_ram_ena", ram_ena, 0);
    step();
    step();
    rsta = 1'b0;
    wr_valid = 1'b0; rd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clka);
      check("post_rst_rsp_valid", rsp_valid, 0);
      step();
    end
    wr_valid = 1'b1; wr_addr = 10'd50; wr_data = 32'h1234_5678;
    rd_valid = 1'b1; rd_addr = 10'd51;
    @(negedge clka);
    check("first_contention_wr", wr_ready, 1);
    check("first_contention_rd", rd_ready, 0);
    step();
    idle(4);

    // Top address.
    do_write(10'd1023, 32'hDEAD_03FF);
    do_read(10'd1023);
    idle(4);

    // Randomised traffic over a small address window to exercise read-after-write.
    for (int i = 0; i < 3000; i++) begin
      wr_valid  = ($urandom_range(0, 2) != 0);
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = $urandom;
      rd_valid  = ($urandom_range(0, 2) != 0);
      rd_addr   = AW'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    idle(6);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
